// File: rtl/sd_sector_server.sv
// Sector responder that serves 512-byte FDC sectors out of an image held in byte memory.
// Optional write protect: define SD_SERVER_WP_EN to add img_wp / wp_err.
module sd_sector_server #(
  parameter int         MEM_AW    = 20,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [31:0]       img_size,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_dout,
  output logic              sd_dout_strobe,
  input  logic [7:0]        sd_din,
  output logic              sd_din_strobe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_d,
  input  logic [7:0]        mem_q,
  input  logic              mem_ready,
  output logic              busy
`ifdef SD_SERVER_WP_EN
  ,
  input  logic              img_wp,
  output logic              wp_err
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_STB, WR_STB, WR_CAP, WR_MEM, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [MEM_AW-10:0] lba_q, lba_d;
  logic [8:0]        index_q, index_d;
  logic [8:0]        buff_addr_q, buff_addr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        mem_d_q, mem_d_d;
  logic              in_range_q, in_range_d;
  logic              got_q, got_d;
  logic              accept;
  logic              adv;
  logic              wp_block;
  logic [41:0]       req_end;
  logic              req_in_range;

  // Wide enough that the largest lba plus one sector cannot wrap.
  assign req_end      = {1'b0, sd_lba, 9'd0} + 42'd512;
  assign req_in_range = (req_end <= {10'd0, img_size});
  assign accept       = (state_q == IDLE) && (sd_rd || sd_wr);

  assign sd_ack         = (state_q != IDLE) && (state_q != DONE);
  assign busy           = (state_q != IDLE);
  assign sd_dout_strobe = (state_q == RD_STB);
  assign sd_din_strobe  = (state_q == WR_STB);
  assign sd_buff_addr   = buff_addr_q;
  assign sd_dout        = dout_q;
  assign mem_d          = mem_d_q;
  assign mem_addr       = {lba_q, index_q};

  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    index_d     = index_q;
    buff_addr_d = buff_addr_q;
    dout_d      = dout_q;
    mem_d_d     = mem_d_q;
    in_range_d  = in_range_q;
    got_d       = got_q;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    adv         = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lba_d       = sd_lba[MEM_AW-10:0];
          in_range_d  = req_in_range;
          index_d     = 9'd0;
          buff_addr_d = 9'd0;
          got_d       = 1'b0;
          state_d     = sd_rd ? RD_REQ : WR_STB;
        end
      end
      RD_REQ: begin
        if (!in_range_q) begin
          dout_d      = FILL_BYTE;
          buff_addr_d = index_q;
          state_d     = RD_STB;
        end else begin
          mem_rd  = 1'b1;
          if (mem_ready) begin
            dout_d = mem_q;
            got_d  = 1'b1;
          end
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A zero-wait memory already answered in RD_REQ; do not issue a second read.
        if (got_q) begin
          buff_addr_d = index_q;
          state_d     = RD_STB;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            dout_d      = mem_q;
            buff_addr_d = index_q;
            state_d     = RD_STB;
          end
        end
      end
      RD_STB: begin
        got_d = 1'b0;
        if (index_q == 9'd511) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 9'd1;
          state_d = RD_REQ;
        end
      end
      WR_STB: state_d = WR_CAP;
      WR_CAP: begin
        mem_d_d = sd_din;
        state_d = WR_MEM;
      end
      WR_MEM: begin
        if (in_range_q && !wp_block) begin
          mem_wr = 1'b1;
          adv    = mem_ready;
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          if (index_q == 9'd511) begin
            state_d = DONE;
          end else begin
            index_d     = index_q + 9'd1;
            buff_addr_d = index_q + 9'd1;
            state_d     = WR_STB;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lba_q       <= '0;
      index_q     <= 9'd0;
      buff_addr_q <= 9'd0;
      dout_q      <= 8'd0;
      mem_d_q     <= 8'd0;
      in_range_q  <= 1'b0;
      got_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      index_q     <= index_d;
      buff_addr_q <= buff_addr_d;
      dout_q      <= dout_d;
      mem_d_q     <= mem_d_d;
      in_range_q  <= in_range_d;
      got_q       <= got_d;
    end
  end

`ifdef SD_SERVER_WP_EN
  logic wp_q, wp_d, wp_err_q, wp_err_d;

  assign wp_block = wp_q;
  assign wp_err   = wp_err_q;

  // The flag reports on the most recent transfer, so any new accept clears it.
  always_comb begin
    wp_d     = wp_q;
    wp_err_d = wp_err_q;
    if (accept) begin
      wp_d     = !sd_rd && img_wp;
      wp_err_d = 1'b0;
    end else if (state_q == DONE && wp_q) begin
      wp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wp_q     <= 1'b0;
      wp_err_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      wp_err_q <= wp_err_d;
    end
  end
`else
  assign wp_block = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server: reads, fill reads, writes, priority, reset abort, write protect.
module tb_sd_sector_server;
  localparam int         MEM_AW = 20;
  localparam logic [7:0] FILL   = 8'h00;

  logic              clk_sys  = 1'b0;
  logic              reset_n  = 1'b0;
  logic [31:0]       img_size = 32'd0;
  logic [31:0]       sd_lba   = 32'd0;
  logic              sd_rd    = 1'b0;
  logic              sd_wr    = 1'b0;
  logic [7:0]        sd_din   = 8'h00;
  logic              sd_ack, sd_dout_strobe, sd_din_strobe;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_dout, mem_d, mem_q;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd, mem_wr, mem_ready, busy;
`ifdef SD_SERVER_WP_EN
  logic              img_wp = 1'b0;
  logic              wp_err;
`endif

  int errors = 0;
  int checks = 0;

  bit       wait_en = 1'b0;
  bit       ready_tgl;
  bit [7:0] mem     [0:(1<<MEM_AW)-1];
  bit       written [0:(1<<MEM_AW)-1];

  sd_sector_server #(.MEM_AW(MEM_AW), .FILL_BYTE(FILL)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .img_size(img_size), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_dout(sd_dout), .sd_dout_strobe(sd_dout_strobe), .sd_din(sd_din),
    .sd_din_strobe(sd_din_strobe), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_d(mem_d), .mem_q(mem_q), .mem_ready(mem_ready), .busy(busy)
`ifdef SD_SERVER_WP_EN
    , .img_wp(img_wp), .wp_err(wp_err)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Memory model: unwritten byte n reads as n[7:0].
  assign mem_ready = (mem_rd || mem_wr) && (!wait_en || ready_tgl);
  assign mem_q     = written[mem_addr] ? mem[mem_addr] : mem_addr[7:0];

  always @(posedge clk_sys) begin
    ready_tgl <= ~ready_tgl;
    if (mem_wr && mem_ready) begin
      mem[mem_addr]     <= mem_d;
      written[mem_addr] <= 1'b1;
    end
    if (sd_din_strobe) sd_din <= ~sd_buff_addr[7:0];
  end

  int         n_dstb = 0, n_istb = 0, n_ack = 0, n_memrd = 0, n_memwr = 0, n_overlap = 0;
  logic [8:0] d_addr [0:16383];
  logic [7:0] d_data [0:16383];
  logic [8:0] i_addr [0:16383];

  always @(negedge clk_sys) begin
    if (sd_dout_strobe) begin
      if (n_dstb < 16384) begin
        d_addr[n_dstb] = sd_buff_addr;
        d_data[n_dstb] = sd_dout;
      end
      n_dstb++;
    end
    if (sd_din_strobe) begin
      if (n_istb < 16384) i_addr[n_istb] = sd_buff_addr;
      n_istb++;
    end
    if (sd_ack) n_ack++;
    if (mem_rd) n_memrd++;
    if (mem_wr) n_memwr++;
    if (mem_rd && mem_wr) n_overlap++;
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] lba,
                        input logic [31:0] size, output bit tmo);
    int k;
    tmo = 1'b0;
    @(posedge clk_sys); #1;
    sd_lba = lba; img_size = size; sd_rd = rd; sd_wr = wr;
    k = 0;
    while (!sd_ack && k < 10) begin @(negedge clk_sys); #1; k++; end
    sd_rd = 1'b0; sd_wr = 1'b0;
    if (!sd_ack) tmo = 1'b1;
    k = 0;
    while (sd_ack && k < 6000) begin @(negedge clk_sys); #1; k++; end
    if (sd_ack) tmo = 1'b1;
    @(negedge clk_sys); #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", sd_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({mem_rd, mem_wr, sd_dout_strobe, sd_din_strobe} !== 4'b0) begin
      errors++; $display("FAIL reset_ctl got=%b exp=0000", {mem_rd, mem_wr, sd_dout_strobe, sd_din_strobe});
    end
    checks++; if ({sd_buff_addr, sd_dout, mem_addr, mem_d} !== '0) begin
      errors++; $display("FAIL reset_data addr=%0d dout=%h maddr=%h md=%h exp=0", sd_buff_addr, sd_dout, mem_addr, mem_d);
    end
`ifdef SD_SERVER_WP_EN
    checks++; if (wp_err !== 1'b0) begin errors++; $display("FAIL reset_wp_err got=%b exp=0", wp_err); end
`endif
    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_read(input string name, input logic wr_too, input logic [31:0] lba,
                           input logic [31:0] size, input bit in_range, input logic [31:0] base,
                           input int exp_ack);
    int s0, a0, r0, i0, w0, bad, bj;
    logic [31:0] t;
    logic [7:0]  e, bd_act, bd_exp;
    logic [8:0]  bd_addr;
    bit tmo;
    s0 = n_dstb; a0 = n_ack; r0 = n_memrd; i0 = n_istb; w0 = n_memwr;
    do_req(1'b1, wr_too, lba, size, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout ack=%b exp=handshake done", name, sd_ack); end
    checks++; if (n_dstb - s0 != 512) begin errors++; $display("FAIL %s_strobes got=%0d exp=512", name, n_dstb - s0); end
    bad = 0; bj = 0; bd_act = 0; bd_exp = 0; bd_addr = 0;
    for (int j = 0; j < 512; j++) begin
      t = base + 32'(j);
      e = in_range ? t[7:0] : FILL;
      if (d_addr[s0 + j] !== j[8:0] || d_data[s0 + j] !== e) begin
        if (bad == 0) begin bj = j; bd_addr = d_addr[s0 + j]; bd_act = d_data[s0 + j]; bd_exp = e; end
        bad++;
      end
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL %s_data bad=%0d first i=%0d addr=%0d dout=%h exp addr=%0d dout=%h", name, bad, bj, bd_addr, bd_act, bj, bd_exp);
    end
    checks++;
    if (!in_range && n_memrd != r0) begin errors++; $display("FAIL %s_memrd got=%0d exp=0", name, n_memrd - r0); end
    else if (in_range && !wait_en && n_memrd - r0 != 512) begin errors++; $display("FAIL %s_memrd got=%0d exp=512", name, n_memrd - r0); end
    else if (in_range && wait_en && n_memrd - r0 < 512) begin errors++; $display("FAIL %s_memrd got=%0d exp>=512", name, n_memrd - r0); end
    checks++; if (n_istb != i0 || n_memwr != w0) begin
      errors++; $display("FAIL %s_no_write din_strobes=%0d mem_wr=%0d exp=0", name, n_istb - i0, n_memwr - w0);
    end
    if (exp_ack != 0) begin
      checks++; if (n_ack - a0 != exp_ack) begin errors++; $display("FAIL %s_ack_cycles got=%0d exp=%0d", name, n_ack - a0, exp_ack); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_idle busy=%b exp=0", name, busy); end
    $display("read %s lba=%0d size=%0d strobes=%0d ack_cycles=%0d mem_rd=%0d", name, lba, size, n_dstb - s0, n_ack - a0, n_memrd - r0);
  endtask

  task automatic test_write(input string name, input logic [31:0] lba, input logic [31:0] size, input bit exp_wr);
    int i0, w0, r0, o0, s0, bad, bj;
    logic [MEM_AW-1:0] a;
    logic [7:0] got, e;
    bit tmo;
    i0 = n_istb; w0 = n_memwr; r0 = n_memrd; o0 = n_overlap; s0 = n_dstb;
    do_req(1'b0, 1'b1, lba, size, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL %s_timeout ack=%b exp=handshake done", name, sd_ack); end
    checks++; if (n_istb - i0 != 512) begin errors++; $display("FAIL %s_din_strobes got=%0d exp=512", name, n_istb - i0); end
    bad = 0; bj = 0;
    for (int j = 0; j < 512; j++) if (i_addr[i0 + j] !== j[8:0]) begin if (bad == 0) bj = j; bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL %s_din_addr bad=%0d first i=%0d got=%0d exp=%0d", name, bad, bj, i_addr[i0 + bj], bj); end
    checks++;
    if (!exp_wr && n_memwr != w0) begin errors++; $display("FAIL %s_memwr got=%0d exp=0", name, n_memwr - w0); end
    else if (exp_wr && !wait_en && n_memwr - w0 != 512) begin errors++; $display("FAIL %s_memwr got=%0d exp=512", name, n_memwr - w0); end
    else if (exp_wr && wait_en && n_memwr - w0 < 512) begin errors++; $display("FAIL %s_memwr got=%0d exp>=512", name, n_memwr - w0); end
    checks++; if (n_overlap != o0 || n_memrd != r0 || n_dstb != s0) begin
      errors++; $display("FAIL %s_no_read overlap=%0d mem_rd=%0d dout_strobes=%0d exp=0", name, n_overlap - o0, n_memrd - r0, n_dstb - s0);
    end
    bad = 0; bj = 0; got = 0; e = 0;
    for (int j = 0; j < 512; j++) begin
      a = {lba[MEM_AW-10:0], 9'(j)};
      if (exp_wr) e = ~a[7:0]; else e = a[7:0];
      if ((written[a] ? mem[a] : a[7:0]) !== e) begin
        if (bad == 0) begin bj = j; got = written[a] ? mem[a] : a[7:0]; end
        bad++;
      end
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL %s_mem bad=%0d first i=%0d got=%h exp=%h", name, bad, bj, got, exp_wr ? ~bj[7:0] : bj[7:0]);
    end
    $display("write %s lba=%0d size=%0d din_strobes=%0d mem_wr=%0d", name, lba, size, n_istb - i0, n_memwr - w0);
  endtask

  task automatic test_reset_mid;
    int s0, s1, k;
    s0 = n_dstb;
    @(posedge clk_sys); #1;
    sd_lba = 32'd3; img_size = 32'd4096; sd_rd = 1'b1;
    k = 0;
    while (!sd_ack && k < 10) begin @(negedge clk_sys); #1; k++; end
    sd_rd = 1'b0;
    k = 0;
    while (n_dstb - s0 < 100 && k < 2000) begin @(negedge clk_sys); #1; k++; end
    checks++; if (n_dstb - s0 != 100) begin errors++; $display("FAIL abort_reach got=%0d exp=100 strobes", n_dstb - s0); end
    reset_n = 1'b0;
    #1;
    checks++; if ({sd_ack, busy, mem_rd, mem_wr, sd_dout_strobe, sd_din_strobe} !== 6'b0) begin
      errors++; $display("FAIL abort_ctl got=%b exp=000000", {sd_ack, busy, mem_rd, mem_wr, sd_dout_strobe, sd_din_strobe});
    end
    checks++; if ({sd_buff_addr, sd_dout, mem_addr} !== '0) begin
      errors++; $display("FAIL abort_data addr=%0d dout=%h maddr=%h exp=0", sd_buff_addr, sd_dout, mem_addr);
    end
    s1 = n_dstb;
    repeat (5) @(negedge clk_sys);
    checks++; if (n_dstb != s1) begin errors++; $display("FAIL abort_quiet strobes_in_reset=%0d exp=0", n_dstb - s1); end
    @(posedge clk_sys); #1 reset_n = 1'b1;
    $display("abort at byte 100 then reset released");
    test_read("after_abort", 1'b0, 32'd2, 32'd4096, 1'b1, 32'd1024, 0);
  endtask

`ifdef SD_SERVER_WP_EN
  task automatic test_wp;
    bit tmo;
    img_wp = 1'b1;
    test_write("wp_lba0", 32'd0, 32'd4096, 1'b0);
    checks++; if (wp_err !== 1'b1) begin errors++; $display("FAIL wp_err_set got=%b exp=1", wp_err); end
    img_wp = 1'b0;
    do_req(1'b1, 1'b0, 32'd0, 32'd4096, tmo);
    checks++; if (tmo || wp_err !== 1'b0) begin errors++; $display("FAIL wp_err_clear got=%b timeout=%b exp=0", wp_err, tmo); end
    $display("read wp_clear lba=0 wp_err=%b", wp_err);
  endtask
`endif

  initial begin
    test_reset;
    test_read("rd_lba3", 1'b0, 32'd3, 32'd4096, 1'b1, 32'd1536, 1536);
    test_read("rd_fill", 1'b0, 32'd8, 32'd4096, 1'b0, 32'd0, 0);
    test_read("rd_edge_in", 1'b0, 32'd7, 32'd4096, 1'b1, 32'd3584, 0);
    test_read("rd_edge_out", 1'b0, 32'd7, 32'd4095, 1'b0, 32'd0, 0);
    test_read("rd_trunc", 1'b0, 32'd2051, 32'hFFFF_FFFF, 1'b1, 32'd1536, 0);
    test_write("wr_lba1", 32'd1, 32'd4096, 1'b1);
    test_write("wr_oor", 32'd9, 32'd4096, 1'b0);
    test_read("rd_wr_both", 1'b1, 32'd2, 32'd4096, 1'b1, 32'd1024, 0);
    wait_en = 1'b1;
    test_read("rd_wait", 1'b0, 32'd5, 32'd4096, 1'b1, 32'd2560, 0);
    test_write("wr_wait", 32'd4, 32'd4096, 1'b1);
    wait_en = 1'b0;
    test_reset_mid;
`ifdef SD_SERVER_WP_EN
    test_wp;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
